// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg -- shared types and constants for the two-master bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, DONE)
//   owner_t     : index of the granted master (0 or 1)
//   WDOG_W      : width of the transfer watchdog counter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog -- counts bus cycles spent waiting for a memory ack.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count (asserted on the grant edge)
//   enable     : one waiting cycle elapsed (BUSY without ack)
//   expired    : this enabled cycle is the TIMEOUT_CYCLES-th one
// Parameter:
//   TIMEOUT_CYCLES : waiting cycles allowed, 1..65535
module arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import bus_arbiter_pkg::*;

    // The count holds the number of waiting cycles already completed, so
    // the cycle that would bring it to TIMEOUT_CYCLES is the expiring one.
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter -- two-master to single-memory arbiter with watchdog abort.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   m{0,1}_req_i/_wr_i         : master request and direction (1 = write)
//   m{0,1}_addr_i/_data_i      : master address and write data
//   m{0,1}_data_o              : last read data returned to master
//   m{0,1}_ack_o / _err_o      : one-cycle completion / timeout pulses
//   rd_en_o, wr_en_o           : memory strobes (only while BUSY)
//   addr_o, data_o             : memory address and write data
//   data_i, ack_i              : memory read data and completion
//   owner_o                    : granted master index
// Parameter:
//   TIMEOUT_CYCLES : waiting cycles before abort, 1..65535
// Configuration macro:
//   BUS_ARBITER_ROUND_ROBIN_EN : defined -> round-robin on simultaneous
//                                requests; undefined -> m0 fixed priority.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic        m0_wr_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_wr_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        rd_en_o,
    output logic        wr_en_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic        owner_o
);
    import bus_arbiter_pkg::*;

    arb_state_t  state;
    owner_t      winner;
    logic        any_req;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic        wr_q;
    logic        wdog_clear;
    logic        wdog_en;
    logic        expired;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    owner_t      last_q;  // master granted most recently
`endif

    always_comb begin
        any_req = m0_req_i | m1_req_i;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        if (m0_req_i && m1_req_i) begin
            winner = ~last_q;
        end else begin
            winner = m0_req_i ? 1'b0 : 1'b1;
        end
`else
        winner = m0_req_i ? 1'b0 : 1'b1;
`endif
        sel_wr   = winner ? m1_wr_i   : m0_wr_i;
        sel_addr = winner ? m1_addr_i : m0_addr_i;
        sel_data = winner ? m1_data_i : m0_data_i;
    end

    assign wdog_clear = (state == ST_IDLE) && any_req;
    assign wdog_en    = (state == ST_BUSY) && !ack_i;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wdog_clear),
        .enable (wdog_en),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner_o   <= 1'b0;
            wr_q      <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
            rd_en_o   <= 1'b0;
            wr_en_o   <= 1'b0;
            m0_ack_o  <= 1'b0;
            m1_ack_o  <= 1'b0;
            m0_err_o  <= 1'b0;
            m1_err_o  <= 1'b0;
            m0_data_o <= '0;
            m1_data_o <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            last_q    <= 1'b1;  // so m0 wins the first tie
`endif
        end else begin
            // completion pulses last exactly one cycle
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_o <= winner;
                        wr_q    <= sel_wr;
                        addr_o  <= sel_addr;
                        data_o  <= sel_data;
                        rd_en_o <= ~sel_wr;
                        wr_en_o <= sel_wr;
                        state   <= ST_BUSY;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                        last_q  <= winner;
`endif
                    end
                end

                ST_BUSY: begin
                    // ack takes precedence over a watchdog expiry in the same cycle
                    if (ack_i) begin
                        rd_en_o <= 1'b0;
                        wr_en_o <= 1'b0;
                        state   <= ST_DONE;
                        if (owner_o == 1'b0) begin
                            m0_ack_o <= 1'b1;
                            if (!wr_q) m0_data_o <= data_i;
                        end else begin
                            m1_ack_o <= 1'b1;
                            if (!wr_q) m1_data_o <= data_i;
                        end
                    end else if (expired) begin
                        rd_en_o <= 1'b0;
                        wr_en_o <= 1'b0;
                        state   <= ST_DONE;
                        if (owner_o == 1'b0) begin
                            m0_err_o <= 1'b1;
                        end else begin
                            m1_err_o <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    rd_en_o <= 1'b0;
                    wr_en_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter -- self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 4).
// A transaction-level model predicts every output after each clock edge;
// directed scenarios add literal expectations, then a randomized run follows.
// Honours BUS_ARBITER_ROUND_ROBIN_EN to select the expected arbitration policy.
module tb_bus_arbiter;

    localparam int unsigned TMO = 4;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, wr;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] data_i;
    logic        ack_i;

    logic [31:0] m0_data_o, m1_data_o, addr_o, data_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        rd_en_o, wr_en_o, owner_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req_i (req[0]),
        .m0_wr_i  (wr[0]),
        .m0_addr_i(addr[0]),
        .m0_data_i(wdat[0]),
        .m0_data_o(m0_data_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_req_i (req[1]),
        .m1_wr_i  (wr[1]),
        .m1_addr_i(addr[1]),
        .m1_data_i(wdat[1]),
        .m1_data_o(m1_data_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .rd_en_o  (rd_en_o),
        .wr_en_o  (wr_en_o),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .data_i   (data_i),
        .ack_i    (ack_i),
        .owner_o  (owner_o)
    );

    // ---------------- transaction-level reference model ----------------
    bit          in_flight;   // a transfer occupies the bus
    bit          gap;         // one dead cycle after each completion
    int unsigned busy_n;      // bus cycles spent on the current transfer
    bit          t_own, t_wr, m_last;
    logic [31:0] t_addr, t_data;
    logic [31:0] m_rd [2];
    bit   [1:0]  m_ack, m_err;

    function automatic bit pick(input logic [1:0] r, input bit last);
        if (r == 2'b11) return RR ? ~last : 1'b0;
        return r[0] ? 1'b0 : 1'b1;
    endfunction

    // Advance the model across one clock edge using the inputs as sampled.
    task automatic model_step();
        bit w;
        m_ack = '0;
        m_err = '0;
        if (!rst_n) begin
            in_flight = 0; gap = 0; busy_n = 0;
            t_own = 0; t_wr = 0; m_last = 1;
            m_rd[0] = '0; m_rd[1] = '0;
        end else if (gap) begin
            gap = 0;
        end else if (in_flight) begin
            busy_n++;
            if (ack_i) begin
                m_ack[t_own] = 1'b1;
                if (!t_wr) m_rd[t_own] = data_i;
                in_flight = 0; gap = 1;
            end else if (busy_n == TMO) begin
                m_err[t_own] = 1'b1;
                in_flight = 0; gap = 1;
            end
        end else if (req != 2'b00) begin
            w = pick(req, m_last);
            t_own = w; t_wr = wr[w]; t_addr = addr[w]; t_data = wdat[w];
            m_last = w; in_flight = 1; busy_n = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict, clock, then compare every output against the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rd_en", rd_en_o, in_flight && !t_wr);
        chk("wr_en", wr_en_o, in_flight && t_wr);
        if (in_flight) begin
            chk("owner", owner_o, t_own);
            chk("addr_o", addr_o, t_addr);
            chk("data_o", data_o, t_data);
        end
        chk("m0_ack", m0_ack_o, m_ack[0]);
        chk("m1_ack", m1_ack_o, m_ack[1]);
        chk("m0_err", m0_err_o, m_err[0]);
        chk("m1_err", m1_err_o, m_err[1]);
        chk("m0_data", m0_data_o, m_rd[0]);
        chk("m1_data", m1_data_o, m_rd[1]);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] grants;
    int         ng;
    bit   [1:0] pend;

    initial begin
        rst_n = 0; req = '0; wr = '0; data_i = '0; ack_i = 0;
        addr[0] = '0; addr[1] = '0; wdat[0] = '0; wdat[1] = '0;
        tick(); tick();
        chk("rst_owner", owner_o, 0);
        chk("rst_strobes", {rd_en_o, wr_en_o}, 0);
        chk("rst_m0_data", m0_data_o, 0);
        rst_n = 1;

        // m0 read, memory acks in the second BUSY cycle
        req[0] = 1; wr[0] = 0; addr[0] = 32'h100;
        tick();
        chk("rd_c1", rd_en_o, 1);
        chk("rd_addr", addr_o, 32'h100);
        tick();
        chk("rd_c2", rd_en_o, 1);
        ack_i = 1; data_i = 32'hDEADBEEF;
        tick();
        chk("rd_ack", m0_ack_o, 1);
        chk("rd_strobe_off", rd_en_o, 0);
        chk("rd_data", m0_data_o, 32'hDEADBEEF);
        req[0] = 0; ack_i = 0; data_i = '0;
        tick(); tick();

        // m1 write, ack already high while idle (ignored) and in first BUSY cycle
        req[1] = 1; wr[1] = 1; addr[1] = 32'h200; wdat[1] = 32'h12345678; ack_i = 1;
        tick();
        chk("wr_c1", wr_en_o, 1);
        chk("wr_data", data_o, 32'h12345678);
        chk("wr_owner", owner_o, 1);
        tick();
        chk("wr_ack", m1_ack_o, 1);
        chk("wr_m0_idle", {m0_ack_o, m0_err_o}, 0);
        chk("wr_strobe_off", wr_en_o, 0);
        req[1] = 0; ack_i = 0;
        tick();

        // both request continuously with zero-wait memory
        req = 2'b11; wr = 2'b00; addr[0] = 32'hA0; addr[1] = 32'hB0; ack_i = 1;
        grants = '0; ng = 0;
        repeat (12) begin
            tick();
            if (rd_en_o && ng < 4) begin
                grants[ng] = owner_o;
                ng++;
            end
        end
        chk("tie_count", ng, 4);
        chk("tie_grants", grants, RR ? 4'b1010 : 4'b0000);
        req = '0; ack_i = 0;
        tick();

        // memory never acks: abort after 4 BUSY cycles
        req[0] = 1; wr[0] = 0; addr[0] = 32'h300;
        repeat (4) tick();
        chk("to_c4", rd_en_o, 1);
        tick();
        chk("to_err", m0_err_o, 1);
        chk("to_noack", m0_ack_o, 0);
        chk("to_strobe_off", rd_en_o, 0);
        req[0] = 0;
        tick();
        req[1] = 1; wr[1] = 0; addr[1] = 32'h400; ack_i = 1; data_i = 32'hCAFEF00D;
        tick(); tick();
        chk("after_to_ack", m1_ack_o, 1);
        chk("after_to_data", m1_data_o, 32'hCAFEF00D);
        req[1] = 0; ack_i = 0;
        tick();

        // ack in the very cycle the watchdog would expire: ack wins
        req[0] = 1; wr[0] = 0; addr[0] = 32'h340;
        repeat (4) tick();
        ack_i = 1; data_i = 32'h0000_55AA;
        tick();
        chk("race_ack", m0_ack_o, 1);
        chk("race_noerr", m0_err_o, 0);
        chk("race_data", m0_data_o, 32'h0000_55AA);
        req[0] = 0; ack_i = 0;
        tick();

        // reset during the second BUSY cycle aborts silently
        req[0] = 1; wr[0] = 0; addr[0] = 32'h500; ack_i = 0;
        tick(); tick();
        rst_n = 0;
        tick();
        chk("rst_busy_strobe", rd_en_o, 0);
        chk("rst_busy_pulses", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
        chk("rst_busy_data", m0_data_o, 0);
        rst_n = 1; req[0] = 0;
        req[1] = 1; wr[1] = 1; addr[1] = 32'h600; wdat[1] = 32'h0BADF00D; ack_i = 1;
        tick(); tick();
        chk("post_rst_ack", m1_ack_o, 1);
        req[1] = 0; ack_i = 0;
        tick();

        // randomized traffic with random memory latency and occasional resets
        pend = '0;
        repeat (3000) begin
            for (int n = 0; n < 2; n++) begin
                if (pend[n] && (m_ack[n] || m_err[n])) begin
                    pend[n] = 0; req[n] = 0;
                end else if (pend[n] && in_flight && t_own == n[0] && $urandom_range(0, 39) == 0) begin
                    pend[n] = 0; req[n] = 0;  // requester walks away mid-transfer
                end else if (!pend[n] && $urandom_range(0, 2) == 0) begin
                    pend[n] = 1; req[n] = 1;
                    wr[n]   = 1'($urandom_range(0, 1));
                    addr[n] = $urandom;
                    wdat[n] = $urandom;
                end
            end
            ack_i  = ($urandom_range(0, 2) == 0);
            data_i = $urandom;
            rst_n  = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
